// File: rtl/axi_rd_arbiter_2to1_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_2to1_if
//   AXI read-channel bundle (AR + R) shared by the two arbiter masters and
//   the slave port.
//   Signals : ARADDR/ARLEN/ARID/ARVALID/ARREADY, RDATA/RRESP/RLAST/RID/
//             RVALID/RREADY.
//   Modports: master - drives AR* and RREADY (the requester side)
//             slave  - drives ARREADY and R*  (the responder side)
// ---------------------------------------------------------------------------
interface axi_rd_arbiter_2to1_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [3:0]            ARLEN;
    logic [ID_WIDTH-1:0]   ARID;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic [ID_WIDTH-1:0]   RID;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARADDR, ARLEN, ARID, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RID, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARID, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RID, RVALID
    );
endinterface

// File: rtl/axi_rd_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_2to1
//   Shares one AXI read port between two masters (m0 = LSU data reads,
//   m1 = instruction fetch). One transaction in flight at a time, held from
//   the AR handshake until the R beat carrying RLAST. Round-robin between
//   the masters; define AXI_ARB_FIXED_PRIO_EN to make m0 always win ties.
//
//   Ports:
//     ACLK    - clock
//     ARESET  - synchronous, active-high reset
//     m0, m1  - master-facing read channels (slave modport)
//     s       - slave-facing read channel (master modport)
//     grant   - one-hot owner {m1,m0}, 00 while idle
// ---------------------------------------------------------------------------
module axi_rd_arbiter_2to1 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi_rd_arbiter_2to1_if.slave    m0,
    axi_rd_arbiter_2to1_if.slave    m1,
    axi_rd_arbiter_2to1_if.master   s,
    output logic [1:0]              grant
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ADDR = 3'b010,
        DATA = 3'b100
    } state_t;

    state_t state_q, state_d;
    logic [1:0] grant_d;
`ifndef AXI_ARB_FIXED_PRIO_EN
    logic last_q, last_d;     // index of the master served most recently
`endif

    // Masters gathered into arrays so the routing is a plain index by owner.
    logic [1:0]                 ar_valid;
    logic [1:0][ADDR_WIDTH-1:0] ar_addr;
    logic [1:0][3:0]            ar_len;
    logic [1:0][ID_WIDTH-1:0]   ar_id;
    logic [1:0]                 r_ready;
    logic [1:0]                 r_vld;
    logic                       sel;      // owner index, valid in ADDR/DATA
    logic                       in_addr, in_data;
    logic                       pick_m1;

    assign ar_valid = {m1.ARVALID, m0.ARVALID};
    assign ar_addr  = {m1.ARADDR,  m0.ARADDR};
    assign ar_len   = {m1.ARLEN,   m0.ARLEN};
    assign ar_id    = {m1.ARID,    m0.ARID};
    assign r_ready  = {m1.RREADY,  m0.RREADY};

    assign sel     = grant[1];
    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign pick_m1 = ~ar_valid[0];
`else
    // On a tie the master not served last wins.
    assign pick_m1 = ar_valid[1] & (~ar_valid[0] | ~last_q);
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            grant   <= 2'b00;
`ifndef AXI_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;  // makes m0 win the first tie
`endif
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
`ifndef AXI_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant;
`ifndef AXI_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|ar_valid) begin
                    state_d = ADDR;
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                end
            end
            // A master that drops ARVALID here leaves us parked in ADDR.
            ADDR: begin
                if (ar_valid[sel] && s.ARREADY)
                    state_d = DATA;
            end
            // Re-arbitration waits for the next IDLE cycle, so requests
            // arriving with the RLAST beat are seen one cycle later.
            DATA: begin
                if (s.RVALID && r_ready[sel] && s.RLAST) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
`ifndef AXI_ARB_FIXED_PRIO_EN
                    last_d  = sel;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Address channel: only the owner reaches the slave, only in ADDR.
    assign s.ARVALID  = in_addr & ar_valid[sel];
    assign s.ARADDR   = in_addr ? ar_addr[sel] : '0;
    assign s.ARLEN    = in_addr ? ar_len[sel]  : '0;
    assign s.ARID     = in_addr ? ar_id[sel]   : '0;
    assign m0.ARREADY = in_addr & grant[0] & s.ARREADY;
    assign m1.ARREADY = in_addr & grant[1] & s.ARREADY;

    // Read data channel: slave beats go to the owner only in DATA.
    assign s.RREADY = in_data & r_ready[sel];
    assign r_vld[0] = in_data & grant[0] & s.RVALID;
    assign r_vld[1] = in_data & grant[1] & s.RVALID;

    assign m0.RVALID = r_vld[0];
    assign m0.RDATA  = r_vld[0] ? s.RDATA : '0;
    assign m0.RRESP  = r_vld[0] ? s.RRESP : '0;
    assign m0.RID    = r_vld[0] ? s.RID   : '0;
    assign m0.RLAST  = r_vld[0] & s.RLAST;

    assign m1.RVALID = r_vld[1];
    assign m1.RDATA  = r_vld[1] ? s.RDATA : '0;
    assign m1.RRESP  = r_vld[1] ? s.RRESP : '0;
    assign m1.RID    = r_vld[1] ? s.RID   : '0;
    assign m1.RLAST  = r_vld[1] & s.RLAST;

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter_2to1
//   Directed bench for the 2:1 AXI read arbiter. A small slave model answers
//   AR requests with bursts whose data is a function of the address; each
//   master request pushes its expected beats into a per-master queue that a
//   monitor pops on every R handshake.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter_2to1;

    logic       ACLK;
    logic       ARESET;
    logic [1:0] grant;

    axi_rd_arbiter_2to1_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) m0 ();
    axi_rd_arbiter_2to1_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) m1 ();
    axi_rd_arbiter_2to1_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) s  ();

    axi_rd_arbiter_2to1 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .m0     (m0),
        .m1     (m1),
        .s      (s),
        .grant  (grant)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    beat_t exp0[$];
    beat_t exp1[$];
    int    ar_order[$];
    int    hs[2]  = '{0, 0};
    int    rl[2]  = '{0, 0};
    int    tgt[2] = '{0, 0};
    int    vectors = 0;
    int    errors  = 0;
    int    ar_delay = 0;

    function automatic logic [31:0] rd_data(input logic [31:0] a, input logic [3:0] b);
        return (a << 4) + 32'(b) + 32'h5A00_0000;
    endfunction

    function automatic logic [1:0] rd_resp(input logic [31:0] a, input logic [3:0] b);
        return a[3:2] ^ b[1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [31:0] sl_addr;
    logic [3:0]  sl_len, sl_id, sl_beat, nb;
    logic        sl_busy;
    int          sl_cnt;

    always @(posedge ACLK) begin
        if (ARESET) begin
            s.ARREADY <= 1'b0;
            s.RVALID  <= 1'b0;
            s.RDATA   <= '0;
            s.RRESP   <= '0;
            s.RID     <= '0;
            s.RLAST   <= 1'b0;
            sl_busy   <= 1'b0;
            sl_cnt    <= 0;
            sl_beat   <= '0;
        end else begin
            if (s.ARVALID && s.ARREADY) begin
                s.ARREADY <= 1'b0;
                sl_busy   <= 1'b1;
                sl_addr   <= s.ARADDR;
                sl_len    <= s.ARLEN;
                sl_id     <= s.ARID;
                sl_cnt    <= 0;
            end else if (!sl_busy && s.ARVALID) begin
                if (sl_cnt >= ar_delay) s.ARREADY <= 1'b1;
                else                    sl_cnt    <= sl_cnt + 1;
            end
            if (sl_busy && (!s.RVALID || s.RREADY)) begin
                if (s.RVALID && s.RLAST) begin
                    s.RVALID <= 1'b0;
                    sl_busy  <= 1'b0;
                end else begin
                    nb = s.RVALID ? sl_beat + 4'd1 : 4'd0;
                    s.RVALID <= 1'b1;
                    s.RDATA  <= rd_data(sl_addr, nb);
                    s.RRESP  <= rd_resp(sl_addr, nb);
                    s.RID    <= sl_id;
                    s.RLAST  <= (nb == sl_len);
                    sl_beat  <= nb;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    task automatic chk_beat(input int m, input beat_t got);
        beat_t e;
        if (m == 0) begin
            check("m0_beat_expected", 64'(exp0.size() != 0), 64'd1);
            if (exp0.size() != 0) begin
                e = exp0.pop_front();
                check("m0_beat", 64'(got), 64'(e));
            end
        end else begin
            check("m1_beat_expected", 64'(exp1.size() != 0), 64'd1);
            if (exp1.size() != 0) begin
                e = exp1.pop_front();
                check("m1_beat", 64'(got), 64'(e));
            end
        end
    endtask

    always @(posedge ACLK) begin
        if (!ARESET) begin
            if (m0.ARVALID && m0.ARREADY) begin hs[0] <= hs[0] + 1; ar_order.push_back(0); end
            if (m1.ARVALID && m1.ARREADY) begin hs[1] <= hs[1] + 1; ar_order.push_back(1); end
            if (m0.RVALID && m0.RREADY) begin
                chk_beat(0, {m0.RDATA, m0.RRESP, m0.RID, m0.RLAST});
                if (m0.RLAST) rl[0] <= rl[0] + 1;
            end
            if (m1.RVALID && m1.RREADY) begin
                chk_beat(1, {m1.RDATA, m1.RRESP, m1.RID, m1.RLAST});
                if (m1.RLAST) rl[1] <= rl[1] + 1;
            end
        end
    end

    // R outputs must be all-zero whenever RVALID is low.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (!m0.RVALID) check("m0_r_zero", 64'({m0.RDATA, m0.RRESP, m0.RID, m0.RLAST}), 64'd0);
            if (!m1.RVALID) check("m1_r_zero", 64'({m1.RDATA, m1.RRESP, m1.RID, m1.RLAST}), 64'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic req(input int m, input logic [31:0] a, input logic [3:0] len, input logic [3:0] id);
        beat_t e;
        for (int b = 0; b <= int'(len); b++) begin
            e.data = rd_data(a, 4'(b));
            e.resp = rd_resp(a, 4'(b));
            e.id   = id;
            e.last = (b == int'(len));
            if (m == 0) exp0.push_back(e); else exp1.push_back(e);
        end
        tgt[m] = hs[m] + 1;
        if (m == 0) begin
            m0.ARADDR = a; m0.ARLEN = len; m0.ARID = id; m0.ARVALID = 1'b1;
        end else begin
            m1.ARADDR = a; m1.ARLEN = len; m1.ARID = id; m1.ARVALID = 1'b1;
        end
    endtask

    task automatic wait_ar(input int m);
        for (int i = 0; i < 100; i++) begin
            if (hs[m] >= tgt[m]) break;
            @(negedge ACLK);
        end
        check($sformatf("m%0d_ar_handshake", m), 64'(hs[m] >= tgt[m]), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp0.size() == 0 && exp1.size() == 0 && !sl_busy) break;
            @(negedge ACLK);
        end
        check({tag, "_drain"}, 64'(exp0.size() + exp1.size()), 64'd0);
        @(negedge ACLK);
    endtask

    task automatic chk_order(input string tag, input int exp);
        int got;
        got = (ar_order.size() != 0) ? ar_order.pop_front() : -1;
        check(tag, 64'(got), 64'(exp));
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        m0.ARVALID = 1'b0;
        m1.ARVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        exp0.delete();
        exp1.delete();
        ar_order.delete();
        ARESET = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int r0;
        ARESET = 1'b1;
        m0.ARADDR = '0; m0.ARLEN = '0; m0.ARID = '0; m0.ARVALID = 1'b0; m0.RREADY = 1'b1;
        m1.ARADDR = '0; m1.ARLEN = '0; m1.ARID = '0; m1.ARVALID = 1'b0; m1.RREADY = 1'b1;
        repeat (3) @(negedge ACLK);

        // Reset state: everything decodes from IDLE.
        check("rst_grant",     64'(grant), 64'd0);
        check("rst_s_arvalid", 64'(s.ARVALID), 64'd0);
        check("rst_s_rready",  64'(s.RREADY), 64'd0);
        check("rst_m0_arrdy",  64'(m0.ARREADY), 64'd0);
        check("rst_m1_rvalid", 64'(m1.RVALID), 64'd0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Lone m1 request.
        req(1, 32'h100, 4'd0, 4'hA);
        check("m1_only_grant_idle", 64'(grant), 64'd0);
        @(negedge ACLK);
        check("m1_only_grant",   64'(grant), 64'b10);
        check("m1_only_s_addr",  64'(s.ARADDR), 64'h100);
        check("m1_only_s_valid", 64'(s.ARVALID), 64'd1);
        check("m1_only_m0_rdy",  64'(m0.ARREADY), 64'd0);
        wait_ar(1);
        m1.ARVALID = 1'b0;
        wait_done("m1_only");

        // Simultaneous requests after reset: m0 first, then m1; twice.
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            req(0, 32'h0, 4'd0, 4'h1);
            req(1, 32'h4, 4'd0, 4'h2);
            @(negedge ACLK);
            check("tie_grant_m0", 64'(grant), 64'b01);
            wait_ar(0);
            m0.ARVALID = 1'b0;
            wait_ar(1);
            m1.ARVALID = 1'b0;
            wait_done("tie");
            chk_order("tie_order_first", 0);
            chk_order("tie_order_second", 1);
        end

        // m0 4-beat burst; m1 waits until the RLAST beat, then is granted.
        req(0, 32'h300, 4'd3, 4'h5);
        wait_ar(0);
        m0.ARVALID = 1'b0;
        req(1, 32'h400, 4'd0, 4'h9);
        r0 = rl[0];
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (rl[0] != r0) break;
            check("burst_m1_blocked", 64'(m1.ARREADY), 64'd0);
        end
        check("burst_grant_idle", 64'(grant), 64'd0);
        @(negedge ACLK);
        check("burst_grant_m1", 64'(grant), 64'b10);
        wait_ar(1);
        m1.ARVALID = 1'b0;
        wait_done("burst");

        // Slow slave AR and back-pressured master R.
        ar_delay  = 2;
        m0.RREADY = 1'b0;
        req(0, 32'h200, 4'd1, 4'h3);
        @(negedge ACLK);
        check("slow_s_arvalid", 64'(s.ARVALID), 64'd1);
        check("slow_m0_arrdy",  64'(m0.ARREADY), 64'd0);
        wait_ar(0);
        m0.ARVALID = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            check("slow_s_rready", 64'(s.RREADY), 64'd0);
        end
        check("slow_m0_rvalid", 64'(m0.RVALID), 64'd1);
        m0.RREADY = 1'b1;
        wait_done("slow");
        ar_delay = 0;

        // Reset in the middle of DATA abandons the burst.
        m0.RREADY = 1'b0;
        req(0, 32'h500, 4'd3, 4'h7);
        wait_ar(0);
        m0.ARVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        check("mid_grant_data",  64'(grant), 64'b01);
        check("mid_m0_rvalid",   64'(m0.RVALID), 64'd1);
        check("mid_s_rready",    64'(s.RREADY), 64'd0);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mid_rst_grant",   64'(grant), 64'd0);
        check("mid_rst_m0_rvld", 64'(m0.RVALID), 64'd0);
        check("mid_rst_s_rrdy",  64'(s.RREADY), 64'd0);
        check("mid_rst_s_arvld", 64'(s.ARVALID), 64'd0);
        check("mid_rst_arrdy",   64'({m1.ARREADY, m0.ARREADY}), 64'd0);
        exp0.delete();
        ARESET = 1'b0;
        m0.RREADY = 1'b1;
        @(negedge ACLK);

        // Both masters kept busy: m0 re-requests right after its handshake.
        do_reset();
        req(0, 32'h600, 4'd0, 4'h1);
        req(1, 32'h700, 4'd0, 4'h2);
        wait_ar(0);
        req(0, 32'h800, 4'd1, 4'h3);
`ifdef AXI_ARB_FIXED_PRIO_EN
        wait_ar(0);
        m0.ARVALID = 1'b0;
        wait_ar(1);
        m1.ARVALID = 1'b0;
        wait_done("cont");
        chk_order("cont_order_0", 0);
        chk_order("cont_order_1", 0);
        chk_order("cont_order_2", 1);
`else
        wait_ar(1);
        m1.ARVALID = 1'b0;
        wait_ar(0);
        m0.ARVALID = 1'b0;
        wait_done("cont");
        chk_order("cont_order_0", 0);
        chk_order("cont_order_1", 1);
        chk_order("cont_order_2", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_rd_arbiter_2to1.md
Name: axi_rd_arbiter_2to1

Overview:
- Two-master to one-slave AXI read-channel arbiter.
- Shares the single read port of the dual-port AXI SRAM between two masters: m0 is the data/LSU read port, m1 is the instruction-fetch port.
- Serialises the masters with round-robin arbitration. One transaction is outstanding at a time, held from AR handshake through the R beat with RLAST.
- The write channel is not touched; it connects directly to the SRAM's other port.

Parameters:
- DATA_WIDTH, 32, read data width.
- ADDR_WIDTH, 32, address width.
- ID_WIDTH, 4, AXI ID width, passed through unmodified.

Ports:
- ACLK  input  1  clock
- ARESET  input  1  reset, synchronous, active-high
- mN_ARADDR (N=0,1)  input  ADDR_WIDTH  master read address
- mN_ARLEN  input  4  master burst length-1
- mN_ARID  input  ID_WIDTH  master read ID
- mN_ARVALID  input  1  master address valid
- mN_ARREADY  output  1  address ready to master
- mN_RDATA  output  DATA_WIDTH  read data to master
- mN_RRESP  output  2  read response to master
- mN_RLAST  output  1  last beat to master
- mN_RID  output  ID_WIDTH  read ID to master
- mN_RVALID  output  1  read data valid to master
- mN_RREADY  input  1  master data ready
- s_ARADDR / s_ARLEN / s_ARID  output  ADDR_WIDTH / 4 / ID_WIDTH  to slave
- s_ARVALID  output  1  to slave
- s_ARREADY  input  1  from slave
- s_RDATA / s_RRESP / s_RID  input  DATA_WIDTH / 2 / ID_WIDTH  from slave
- s_RLAST  input  1  from slave
- s_RVALID  input  1  from slave
- s_RREADY  output  1  to slave
- grant  output  2  one-hot current owner, 00 when idle

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARESET is synchronous and active-high: sampled on the ACLK rising edge, effective while 1.
- Registers: state (IDLE/ADDR/DATA, one-hot 3'b001/010/100), grant[1:0], last[0] (index of the last master served).
- Reset values: state=IDLE, grant=00, last=1 (so m0 wins the first tie).
- Output reset: every output is 0, because all outputs decode from IDLE.
- IDLE:
  - If any mN_ARVALID, register the winner into grant and go to ADDR next cycle. Arbitration costs 1 cycle of latency.
  - Tie (both valid): winner = !last.
  - All mN_ARREADY=0, s_ARVALID=0, s_RREADY=0.
- ADDR:
  - s_AR* and s_ARVALID are driven combinationally from the granted master.
  - Granted mN_ARREADY = s_ARREADY; the non-granted ARREADY is 0.
  - On s_ARVALID && s_ARREADY, go to DATA.
  - If the granted master drops ARVALID (protocol violation), stay in ADDR; only reset recovers.
- DATA:
  - s_R* is routed to the granted master. Granted mN_RVALID = s_RVALID; s_RREADY = granted mN_RREADY.
  - Non-granted mN_RVALID=0.
  - Each s_RVALID && s_RREADY beat is forwarded.
  - On a beat with s_RLAST=1: go to IDLE, set last = granted index, clear grant.
  - The next grant is decided in the following IDLE cycle, so there are no back-to-back grants: a minimum of 1 idle cycle between transactions.
- Data path:
  - mN_RDATA/RRESP/RID/RLAST carry s_R* unmodified whenever mN_RVALID=1, and are 0 otherwise.
  - ARLEN and ID are not altered; bursts are forwarded up to RLAST.
- Boundary conditions:
  - s_RVALID outside DATA is ignored (s_RREADY=0).
  - A non-granted master's ARVALID waits with no timeout; fairness is guaranteed by round-robin.
  - A new request asserted in the same cycle as the RLAST beat is considered in the next IDLE cycle.
  - Reset mid-transaction returns to IDLE next edge and abandons the transaction. The slave shares the reset.

Optional Feature:
- Macro: AXI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, m0 always wins when both are valid; last is unused and m1 can starve.
- Undefined: round-robin as above.

Test Plan:
- Reset, then only m1_ARVALID=1 with ARADDR=0x100 and ARLEN=0 → grant=10 after 1 cycle; s_ARADDR=0x100; m1 gets RDATA and RLAST=1; m0_RVALID stays 0.
- Both ARVALID in the same cycle after reset, addresses 0x0 and 0x4 → m0 served first, then m1. Repeat both → m0 then m1 again, because last alternates.
- m0 ARLEN=3 burst while m1 requests mid-burst → m1_ARREADY=0 until m0's 4th beat with RLAST. m1 is granted 1 cycle later.
- Slave delays s_ARREADY 2 cycles and m0_RREADY is held low 3 cycles → no beat is lost; s_RREADY=0 while m0_RREADY=0.
- Assert ARESET while in DATA → next cycle state=IDLE, all valids/readies=0, grant=00.
- With AXI_ARB_FIXED_PRIO_EN, both masters continuously valid → m0 wins every arbitration.
